// File: rtl/dds_wave_analyzer.sv
// Measures period, half peak-to-peak amplitude and equivalent tuning word of a
// signed 12-bit sample stream using hysteresis crossings and a serial divider.
module dds_wave_analyzer #(
  parameter int HYST = 64,
  parameter int PW   = 16
) (
  input  logic          clk_in,
  input  logic          rst_n_in,
  input  logic          enable_in,
  input  logic [11:0]   sample_in,
  output logic [PW-1:0] period_out,
  output logic [11:0]   amp_out,
  output logic [11:0]   ftw_out,
  output logic          valid_out,
  output logic          busy_out,
  output logic          timeout_out
);
  typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;

  localparam logic [PW-1:0]      CNT_LAST = PW'((1 << PW) - 2);
  localparam logic signed [11:0] HI       = 12'(HYST);
  localparam logic signed [11:0] LO       = 12'(-HYST);

  state_t             state, state_next;
  logic signed [11:0] s;
  logic               armed;
  logic [PW-1:0]      cnt;
  logic signed [11:0] max_r, min_r;
  logic               busy;
  logic [3:0]         div_it;
  logic [PW-1:0]      div_d, div_rem, rem_next;
  logic [12:0]        div_dvd, div_q, q_next;
  logic [PW:0]        trial;
  logic               ge;
  logic [12:0]        diff;
  logic [11:0]        amp_new, amp_hold;
  logic               measuring, qual, open_edge, close_edge;
  logic               timeout_hit, div_done, accept;

  assign s          = sample_in;
  assign measuring  = (state == ARM) || (state == MEASURE);
  assign qual       = measuring && armed && (s >= HI);
  assign open_edge  = qual && (state == ARM);
  assign close_edge = qual && (state == MEASURE);
  // A crossing outranks a timeout that lands on the same edge.
  assign timeout_hit = measuring && !qual && (cnt == CNT_LAST);
  assign div_done    = busy && (div_it == 4'd12);
  assign accept      = close_edge && (!busy || div_done);

  assign diff     = 13'(max_r) - 13'(min_r);
  assign amp_new  = 12'(diff >> 1);
  assign trial    = {div_rem, div_dvd[12]};
  assign ge       = trial >= {1'b0, div_d};
  assign rem_next = ge ? PW'(trial - {1'b0, div_d}) : PW'(trial);
  assign q_next   = {div_q[11:0], ge};
  assign busy_out = busy;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= IDLE;
    else           state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (!enable_in) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    state_next = ARM;
        ARM:     if (open_edge) state_next = MEASURE;
        MEASURE: if (timeout_hit) state_next = ARM;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      armed       <= 1'b0;
      cnt         <= '0;
      max_r       <= '0;
      min_r       <= '0;
      busy        <= 1'b0;
      div_it      <= '0;
      div_d       <= '0;
      div_rem     <= '0;
      div_dvd     <= '0;
      div_q       <= '0;
      amp_hold    <= '0;
      period_out  <= '0;
      amp_out     <= '0;
      ftw_out     <= '0;
      valid_out   <= 1'b0;
      timeout_out <= 1'b0;
    end else if (!enable_in) begin
      armed     <= 1'b0;
      cnt       <= '0;
      max_r     <= '0;
      min_r     <= '0;
      busy      <= 1'b0;
      div_it    <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= 1'b0;

      if (state == IDLE || timeout_hit) begin
        armed <= 1'b0;
        cnt   <= '0;
      end else begin
        if (qual)          armed <= 1'b0;
        else if (s <= LO)  armed <= 1'b1;
        cnt <= qual ? '0 : cnt + 1'b1;
      end

      // The crossing sample opens the window, so it seeds both peaks.
      if (qual) begin
        max_r <= s;
        min_r <= s;
      end else if (state == MEASURE) begin
        if (s > max_r) max_r <= s;
        if (s < min_r) min_r <= s;
      end

      if (accept) begin
        busy     <= 1'b1;
        div_d    <= cnt + 1'b1;
        div_rem  <= '0;
        div_dvd  <= 13'h1000;
        div_q    <= '0;
        div_it   <= '0;
        amp_hold <= amp_new;
      end else if (busy) begin
        div_rem <= rem_next;
        div_dvd <= {div_dvd[11:0], 1'b0};
        div_q   <= q_next;
        div_it  <= div_it + 4'd1;
        if (div_done) busy <= 1'b0;
      end

      if (div_done) begin
        valid_out  <= 1'b1;
        period_out <= div_d;
        amp_out    <= amp_hold;
        ftw_out    <= q_next[12] ? 12'hFFF : q_next[11:0];
      end

      if (timeout_hit)   timeout_out <= 1'b1;
      else if (div_done) timeout_out <= 1'b0;
    end
  end
endmodule

// File: tb/tb_dds_wave_analyzer.sv
// Table-driven waveform scenarios plus abort/timeout sequences, checked every
// cycle against a behavioural model feeding an expected-result queue.
module tb_dds_wave_analyzer;
  localparam int HYST    = 64;
  localparam int PW      = 14;
  localparam int CNT_MAX = (1 << PW) - 1;

  logic          clk_in = 1'b0;
  logic          rst_n_in, enable_in;
  logic [11:0]   sample_in;
  logic [PW-1:0] period_out;
  logic [11:0]   amp_out, ftw_out;
  logic          valid_out, busy_out, timeout_out;

  always #5 clk_in = ~clk_in;

  dds_wave_analyzer #(.HYST(HYST), .PW(PW)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .enable_in(enable_in),
    .sample_in(sample_in), .period_out(period_out), .amp_out(amp_out),
    .ftw_out(ftw_out), .valid_out(valid_out), .busy_out(busy_out),
    .timeout_out(timeout_out)
  );

  typedef struct { int due; int period; int amp; int ftw; } result_t;
  typedef struct {
    string name; int kind; int half; int cycles;
    int exp_period; int exp_amp; int exp_ftw; int exp_spacing;
  } vector_t;

  result_t sb[$];
  vector_t vectors[3];
  int sine_tab[16] = '{0, 19, 35, 46, 50, 46, 35, 19, 0, -19, -35, -46, -50, -46, -35, -19};

  int n_vec = 0, n_bad = 0, cyc = 0;
  int m_state, m_open, m_clear, m_mx, m_mn, m_busy_end, last_close;
  bit m_armed, m_to_hit;
  int exp_period, exp_amp, exp_ftw;
  bit exp_timeout;

  task automatic check_output(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_bad++;
      $display("[TB] FAIL %s at edge %0d: got %0d, required %0d", name, cyc, act, req);
    end
  endtask

  function automatic int wave(input int kind, input int half, input int t);
    case (kind)
      0:       return ((t % (2 * half)) < half) ? 2047 : -2047;
      1:       return -2048 + 64 * (t % 64);
      default: return sine_tab[t % 16];
    endcase
  endfunction

  function automatic void model_reset();
    m_state = 0; m_armed = 0; m_busy_end = -1; m_to_hit = 0;
    m_open = 0; m_clear = 0; m_mx = 0; m_mn = 0;
    exp_period = 0; exp_amp = 0; exp_ftw = 0; exp_timeout = 0;
    sb.delete();
  endfunction

  // Behaviour at one rising edge, in terms of edge indices since opening/clearing.
  function automatic void model_step(input bit en, input int s);
    bit qual;
    result_t r;
    m_to_hit = 0;
    if (!en) begin
      m_state = 0; m_armed = 0; m_busy_end = -1; sb.delete();
      return;
    end
    if (m_state == 0) begin
      m_state = 1; m_armed = 0; m_clear = cyc;
      return;
    end
    qual = m_armed && (s >= HYST);
    if (qual) m_armed = 0;
    else if (s <= -HYST) m_armed = 1;
    if (qual && m_state == 1) begin
      m_state = 2; m_open = cyc; m_clear = cyc; m_mx = s; m_mn = s;
    end else if (qual) begin
      last_close = cyc;
      if (cyc >= m_busy_end) begin
        r.due = cyc + 13;
        r.period = cyc - m_open;
        r.amp = (m_mx - m_mn) / 2;
        r.ftw = (4096 / r.period > 4095) ? 4095 : 4096 / r.period;
        sb.push_back(r);
        m_busy_end = cyc + 13;
      end
      m_open = cyc; m_clear = cyc; m_mx = s; m_mn = s;
    end else if (cyc - m_clear == CNT_MAX) begin
      m_to_hit = 1; m_state = 1; m_armed = 0; m_clear = cyc;
    end else if (m_state == 2) begin
      if (s > m_mx) m_mx = s;
      if (s < m_mn) m_mn = s;
    end
  endfunction

  task automatic check_cycle();
    result_t r;
    bit ev;
    ev = (sb.size() > 0) && (sb[0].due == cyc);
    check_output("valid_out", int'(valid_out), int'(ev));
    if (ev) begin
      r = sb.pop_front();
      exp_period = r.period; exp_amp = r.amp; exp_ftw = r.ftw; exp_timeout = 0;
    end
    if (m_to_hit) exp_timeout = 1;
    check_output("busy_out", int'(busy_out), int'(cyc < m_busy_end));
    check_output("timeout_out", int'(timeout_out), int'(exp_timeout));
    check_output("period_out", int'(period_out), exp_period);
    check_output("amp_out", int'(amp_out), exp_amp);
    check_output("ftw_out", int'(ftw_out), exp_ftw);
  endtask

  task automatic apply_stimulus(input bit en, input int s);
    enable_in = en;
    sample_in = 12'(s);
    @(posedge clk_in);
    cyc++;
    model_step(en, s);
    #1;
    check_cycle();
  endtask

  task automatic check_all_zero(input string name);
    check_output({name, " period"}, int'(period_out), 0);
    check_output({name, " amp"}, int'(amp_out), 0);
    check_output({name, " ftw"}, int'(ftw_out), 0);
    check_output({name, " valid"}, int'(valid_out), 0);
    check_output({name, " busy"}, int'(busy_out), 0);
    check_output({name, " timeout"}, int'(timeout_out), 0);
  endtask

  initial begin
    int n_valids, prev_valid, en_edge, to_edge, first_valid, held_p, held_a, held_f;
    bit found;
    vectors[0] = '{"square 8/8", 0, 8, 240, 16, 2047, 256, 16};
    vectors[1] = '{"sawtooth 64", 1, 0, 480, 64, 2016, 64, 64};
    vectors[2] = '{"square 2/2", 0, 2, 240, 4, 2047, 1024, 16};

    rst_n_in = 1'b1; enable_in = 1'b0; sample_in = '0;
    model_reset();
    #2 rst_n_in = 1'b0;
    #1 check_all_zero("reset");
    repeat (2) @(posedge clk_in);
    #1 rst_n_in = 1'b1;

    foreach (vectors[i]) begin
      apply_stimulus(0, 0);
      apply_stimulus(0, 0);
      n_valids = 0; prev_valid = -1;
      for (int t = 0; t < vectors[i].cycles; t++) begin
        apply_stimulus(1, wave(vectors[i].kind, vectors[i].half, t));
        if (valid_out) begin
          if (prev_valid >= 0)
            check_output({vectors[i].name, " spacing"}, cyc - prev_valid, vectors[i].exp_spacing);
          prev_valid = cyc;
          n_valids++;
          check_output({vectors[i].name, " period"}, int'(period_out), vectors[i].exp_period);
          check_output({vectors[i].name, " amp"}, int'(amp_out), vectors[i].exp_amp);
          check_output({vectors[i].name, " ftw"}, int'(ftw_out), vectors[i].exp_ftw);
        end
      end
      check_output({vectors[i].name, " enough valids"},
                   int'(n_valids >= vectors[i].cycles / vectors[i].exp_spacing - 3), 1);
    end

    // Small sine never arms, so only the timeout fires; a square then clears it.
    apply_stimulus(0, 0);
    apply_stimulus(0, 0);
    en_edge = cyc + 1; to_edge = -1;
    for (int t = 0; t < CNT_MAX + 20; t++) begin
      apply_stimulus(1, wave(2, 0, t));
      if (timeout_out && to_edge < 0) to_edge = cyc;
    end
    check_output("timeout rise delay", to_edge - en_edge, CNT_MAX);
    found = 0;
    for (int t = 0; t < 80 && !found; t++) begin
      apply_stimulus(1, wave(0, 8, t));
      if (valid_out) begin
        found = 1;
        check_output("timeout cleared by valid", int'(timeout_out), 0);
      end
    end
    check_output("valid after timeout", int'(found), 1);

    // Reset five clocks after a closing edge while the divide is running.
    apply_stimulus(0, 0);
    apply_stimulus(0, 0);
    last_close = -1; found = 0;
    for (int t = 0; t < 100 && !found; t++) begin
      apply_stimulus(1, wave(0, 8, t));
      if (last_close > 0 && cyc == last_close + 5) found = 1;
    end
    check_output("reset abort reached", int'(found), 1);
    check_output("busy before reset", int'(busy_out), 1);
    #2 rst_n_in = 1'b0;
    #1 check_all_zero("async reset");
    model_reset();
    repeat (2) @(posedge clk_in);
    cyc += 2;
    #1 rst_n_in = 1'b1;
    n_valids = 0;
    for (int t = 0; t < 20; t++) begin
      apply_stimulus(1, wave(0, 8, t));
      if (valid_out) n_valids++;
    end
    check_output("no valid after reset", n_valids, 0);

    // Enable drop five clocks after a closing edge, with earlier results held.
    apply_stimulus(0, 0);
    apply_stimulus(0, 0);
    last_close = -1; first_valid = -1; found = 0;
    for (int t = 0; t < 200 && !found; t++) begin
      apply_stimulus(1, wave(0, 8, t));
      if (valid_out && first_valid < 0) first_valid = cyc;
      if (first_valid >= 0 && last_close > first_valid && cyc == last_close + 5) found = 1;
    end
    check_output("enable abort reached", int'(found), 1);
    check_output("busy before abort", int'(busy_out), 1);
    held_p = int'(period_out); held_a = int'(amp_out); held_f = int'(ftw_out);
    apply_stimulus(0, 0);
    check_output("abort busy low", int'(busy_out), 0);
    check_output("abort period held", int'(period_out), 16);
    check_output("abort amp held", int'(amp_out), 2047);
    check_output("abort ftw held", int'(ftw_out), 256);
    n_valids = 0;
    for (int t = 0; t < 20; t++) begin
      apply_stimulus(0, 0);
      if (valid_out) n_valids++;
    end
    check_output("no valid after abort", n_valids, 0);
    check_output("held period stable", int'(period_out), held_p);
    check_output("held amp stable", int'(amp_out), held_a);
    check_output("held ftw stable", int'(ftw_out), held_f);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
